// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC sequencing controller.
package mac_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned ACC_W_DEF  = 12;
    localparam int unsigned CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Command, operand stream and result handshake bundle of the MAC controller.
interface mac_seq_ctrl_if
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);

    logic              START;
    logic [CNT_W-1:0]  LEN;
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [ACC_W-1:0]  RESULT;
    logic              BUSY;
    logic              OVF;

    modport master (
        output START, LEN, IN_VALID, A, B, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, BUSY, OVF
    );

    modport slave (
        input  START, LEN, IN_VALID, A, B, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, BUSY, OVF
    );

endinterface

// File: rtl/mac_datapath.sv
// Multiplier, product register and carry-tracking accumulator for the MAC unit.
module mac_datapath #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              pv,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    localparam int unsigned PW = 2 * DATA_W;

    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] p;
    logic [ACC_W:0]   sum;

    assign prod = PW'(a) * PW'(b);
    assign sum  = {1'b0, acc} + {1'b0, p};

    // Accumulate of the previous product and load of a new one share an edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            p   <= '0;
            pv  <= 1'b0;
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            pv  <= 1'b0;
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            if (pv) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum[ACC_W];
            end
            if (accept) begin
                p  <= ACC_W'(prod);
                pv <= 1'b1;
            end else begin
                pv <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer: accepts START/LEN, streams LEN operand pairs into the
// datapath and presents the accumulated sum on a valid/ready result port.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    mac_seq_ctrl_if.slave  bus
);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             clear;
    logic             accept;
    logic             pv;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    assign clear  = (state == IDLE) && bus.START;
    assign accept = in_ready_q && bus.IN_VALID;

    mac_datapath #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_datapath (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (clear),
        .accept (accept),
        .a      (bus.A),
        .b      (bus.B),
        .pv     (pv),
        .acc    (acc),
        .ovf    (ovf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            len_q       <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        len_q  <= bus.LEN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        if (bus.LEN == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state      <= RUN;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == len_q - CNT_W'(1)) begin
                            state      <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                // Stay until the last product has been folded into ACC.
                DRAIN: begin
                    if (!pv) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.OUT_READY) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.BUSY      = busy_q;
    assign bus.RESULT    = acc;
    assign bus.OVF       = ovf;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench: a 12-bit and an 8-bit accumulator instance share one
// stimulus stream and are checked against job-level sum-of-products arithmetic.
module tb_mac_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_ready;

    int total;
    int bad;

    int unsigned op_a [16];
    int unsigned op_b [16];

    mac_seq_ctrl_if #(.DATA_W(4), .ACC_W(12), .CNT_W(4)) bus12 ();
    mac_seq_ctrl_if #(.DATA_W(4), .ACC_W(8),  .CNT_W(4)) bus8 ();

    assign bus12.START     = start;
    assign bus12.LEN       = len;
    assign bus12.IN_VALID  = in_valid;
    assign bus12.A         = a;
    assign bus12.B         = b;
    assign bus12.OUT_READY = out_ready;
    assign bus8.START      = start;
    assign bus8.LEN        = len;
    assign bus8.IN_VALID   = in_valid;
    assign bus8.A          = a;
    assign bus8.B          = b;
    assign bus8.OUT_READY  = out_ready;

    mac_seq_ctrl #(.DATA_W(4), .ACC_W(12), .CNT_W(4)) u_dut12 (
        .CLK (clk),
        .RST (rst),
        .bus (bus12)
    );

    mac_seq_ctrl #(.DATA_W(4), .ACC_W(8), .CNT_W(4)) u_dut8 (
        .CLK (clk),
        .RST (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  32'(bus12.IN_READY),  0);
        chk({tag, "_out_valid"}, 32'(bus12.OUT_VALID), 0);
        chk({tag, "_busy"},      32'(bus12.BUSY),      0);
        chk({tag, "_ovf"},       32'(bus12.OVF),       0);
        chk({tag, "_result"},    32'(bus12.RESULT),    0);
        chk({tag, "_result8"},   32'(bus8.RESULT),     0);
        chk({tag, "_busy8"},     32'(bus8.BUSY),       0);
    endtask

    // One complete job using op_a/op_b[0..n-1]; gap<0 means random gaps.
    task automatic run_job(input int unsigned n, input int gap,
                           input int unsigned hold, input bit noise);
        longint unsigned sop;
        logic [31:0]     exp12;
        logic [31:0]     exp8;
        int unsigned     g;

        sop = 0;
        for (int unsigned i = 0; i < n; i++) sop += longint'(op_a[i] * op_b[i]);
        exp12 = 32'(sop % 4096);
        exp8  = 32'(sop % 256);

        start = 1'b1; len = 4'(n); in_valid = 1'b0; out_ready = 1'b0;
        tick();
        start = 1'b0; len = 4'($urandom);
        chk("start_busy",      32'(bus12.BUSY),      1);
        chk("start_result",    32'(bus12.RESULT),    0);
        chk("start_ovf8",      32'(bus8.OVF),        0);
        chk("start_in_ready",  32'(bus12.IN_READY),  32'(n != 0));
        chk("start_out_valid", 32'(bus12.OUT_VALID), 32'(n == 0));

        for (int unsigned i = 0; i < n; i++) begin
            g = (gap < 0) ? $urandom_range(0, 3) : int'(gap);
            for (int unsigned j = 0; j < g; j++) begin
                in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom);
                if (noise) begin
                    start = 1'b1; len = 4'($urandom);
                end
                tick();
                start = 1'b0;
                chk("gap_in_ready",  32'(bus12.IN_READY),  1);
                chk("gap_out_valid", 32'(bus12.OUT_VALID), 0);
            end
            in_valid = 1'b1; a = 4'(op_a[i]); b = 4'(op_b[i]);
            tick();
            if (i + 1 < n) chk("run_in_ready", 32'(bus12.IN_READY), 1);
        end

        if (n != 0) begin
            in_valid = 1'b1; a = 4'($urandom); b = 4'($urandom);
            chk("drain_in_ready", 32'(bus12.IN_READY),  0);
            chk("lat_k0",         32'(bus12.OUT_VALID), 0);
            tick();
            chk("lat_k1",         32'(bus12.OUT_VALID), 0);
            tick();
            chk("lat_k2",         32'(bus12.OUT_VALID), 1);
            chk("lat_k2_8",       32'(bus8.OUT_VALID),  1);
        end

        chk("done_result",   32'(bus12.RESULT), exp12);
        chk("done_ovf",      32'(bus12.OVF),    32'(sop >= 4096));
        chk("done_result8",  32'(bus8.RESULT),  exp8);
        chk("done_ovf8",     32'(bus8.OVF),     32'(sop >= 256));
        chk("done_in_ready", 32'(bus12.IN_READY), 0);

        for (int unsigned h = 0; h < hold; h++) begin
            out_ready = 1'b0; in_valid = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
            if (noise) begin
                start = 1'b1; len = 4'($urandom);
            end
            tick();
            start = 1'b0;
            chk("hold_out_valid", 32'(bus12.OUT_VALID), 1);
            chk("hold_result",    32'(bus12.RESULT),    exp12);
            chk("hold_result8",   32'(bus8.RESULT),     exp8);
        end

        out_ready = 1'b1; start = noise; len = 4'($urandom); in_valid = 1'b0;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("hs_out_valid", 32'(bus12.OUT_VALID), 0);
        chk("hs_busy",      32'(bus12.BUSY),      0);
        chk("hs_result",    32'(bus12.RESULT),    exp12);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("idle_busy",    32'(bus12.BUSY),      0);
        chk("idle_ready",   32'(bus12.IN_READY),  0);
        chk("idle_result8", 32'(bus8.RESULT),     exp8);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // basic back-to-back job
        op_a[0] = 2;  op_b[0] = 3;
        op_a[1] = 4;  op_b[1] = 5;
        op_a[2] = 15; op_b[2] = 15;
        run_job(3, 0, 0, 1'b0);

        // gapped operands and result backpressure
        op_a[0] = 7; op_b[0] = 7;
        op_a[1] = 1; op_b[1] = 9;
        run_job(2, 3, 5, 1'b0);

        // empty job
        run_job(0, 0, 2, 1'b0);

        // 8-bit instance wraps and flags carry, next job clears it
        op_a[0] = 15; op_b[0] = 15;
        op_a[1] = 15; op_b[1] = 15;
        run_job(2, 0, 1, 1'b0);
        op_a[0] = 1; op_b[0] = 1;
        run_job(1, 0, 0, 1'b0);

        // reset in the middle of a job
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 4'd13; b = 4'd11;
            tick();
        end
        rst = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk_all_zero("midrst");
        op_a[0] = 3; op_b[0] = 3;
        run_job(1, 0, 0, 1'b0);

        // START noise during RUN and DONE
        for (int unsigned i = 0; i < 5; i++) begin
            op_a[i] = $urandom_range(0, 15);
            op_b[i] = $urandom_range(0, 15);
        end
        run_job(5, 2, 3, 1'b1);

        // randomized jobs including the longest LEN
        for (int k = 0; k < 40; k++) begin
            int unsigned n;
            n = (k == 0) ? 15 : $urandom_range(0, 15);
            for (int unsigned i = 0; i < 16; i++) begin
                op_a[i] = $urandom_range(0, 15);
                op_b[i] = $urandom_range(0, 15);
            end
            run_job(n, -1, $urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencing controller for the MAC unit.
- Accepts a START command with a term count LEN, then consumes LEN operand pairs (A,B) over a valid/ready stream.
- Drives an internal multiply stage and accumulator, and returns the sum of products on a valid/ready result port.
- Sits between the operand source (memory/testbench) and the downstream result consumer.

Parameters:
- DATA_W, 4, operand width (unsigned).
- ACC_W, 12, accumulator/result width; must be ≥ 2*DATA_W.
- CNT_W, 4, width of LEN and the internal term counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle command pulse; honoured only in IDLE.
- LEN  in  CNT_W  number of terms; latched on accepted START.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  controller can accept an operand pair.
- A  in  DATA_W  operand A.
- B  in  DATA_W  operand B.
- OUT_VALID  out  1  RESULT valid.
- OUT_READY  in  1  consumer accepts RESULT.
- RESULT  out  ACC_W  accumulated sum of products.
- BUSY  out  1  high in any state other than IDLE.
- OVF  out  1  sticky accumulator carry-out flag for the current job.

Behaviour:
- Design-wide rule: one clock; reset is synchronous and active-high.
- Reset, at the next CLK edge with RST=1:
  - state=IDLE.
  - Counter, ACC, product register P and its valid flag PV all cleared.
  - All outputs 0: IN_READY, OUT_VALID, BUSY, OVF, RESULT.
  - RST overrides every other input, including mid-job; the partial job is discarded.
- States:
  - IDLE: START=1 → latch LEN, clear ACC/OVF/counter. If LEN=0 go to DONE, otherwise go to RUN.
  - RUN: IN_READY=1.
    - On IN_VALID&IN_READY: P<=A*B (full 2*DATA_W, zero-extended to ACC_W), PV<=1, counter+1.
    - When the accepted pair is term LEN (counter==LEN-1), go to DRAIN.
    - IN_VALID low: hold; no counter change.
  - DRAIN: IN_READY=0; wait one cycle for the final accumulate, then go to DONE.
  - DONE: OUT_VALID=1, RESULT stable. On OUT_READY=1 go to IDLE; OUT_VALID drops the following cycle.
- Accumulate: every edge with PV=1, {carry,ACC}<=ACC+P; PV clears if no new pair is accepted that edge. Back-to-back accepts give one accumulate per cycle.
- Arithmetic: unsigned, modulo 2^ACC_W (ACC wraps). Any carry-out sets OVF, which stays set until the next accepted START.
- Latency: last pair accepted at edge k → OUT_VALID high after edge k+2. For LEN=0, OUT_VALID is high after the edge following START.
- RESULT equals ACC at all times. After return to IDLE it holds its value until the next START clears it.
- START outside IDLE is ignored, including START in the same cycle as the DONE handshake.
- LEN and operand inputs are sampled only on accepted START or accepted transfer; other changes are ignored.
- LEN max = 2^CNT_W-1; counter does not wrap within a job.
- State encoding: one-hot or binary, implementer's choice. No latches; all registers on CLK.

Decomposition:
- Shared package mac_pkg:
  - state localparams (IDLE, RUN, DRAIN, DONE).
  - default DATA_W/ACC_W/CNT_W constants.
- Sub-module mac_datapath: multiplier, P/PV register, accumulator with carry and OVF.
  - Controlled by load/clear/accept strobes from the FSM in mac_seq_ctrl.

Test Plan:
1. Basic job: START, LEN=3, pairs (2,3),(4,5),(15,15) streamed back-to-back, OUT_READY=1 → RESULT=251, OVF=0, OUT_VALID exactly 2 cycles after the third accept, BUSY low the cycle after the handshake.
2. Backpressure: LEN=2, IN_VALID gaps of 3 cycles between (7,7),(1,9); OUT_READY low for 5 cycles in DONE → RESULT=58 held stable with OUT_VALID=1 for all 5 cycles; no extra accepts.
3. LEN=0 → OUT_VALID high the cycle after START, RESULT=0, IN_READY never asserted.
4. Overflow (ACC_W=8 override): LEN=2, (15,15),(15,15) → RESULT=194, OVF=1. Next START with LEN=1, (1,1) → RESULT=1, OVF=0.
5. Reset mid-RUN: LEN=4, assert RST after 2 accepts → all outputs 0 next cycle. New START LEN=1, (3,3) → RESULT=9.
6. START pulsed during RUN and again during DONE with a different LEN → ignored; the job completes with the original LEN and correct sum.
